multiplier_shift_add: RTL and testbench

Parametrised sequential shift-and-add multiplier producing a full-width 2·WIDTH-bit product from two WIDTH-bit operands. It supports unsigned and two's-complement signed operands, selected per operation, and uses a start/busy/done handshake. It replaces the fixed 4-bit multiplier in the arithmetic lab datapath; its product output feeds the seven-segment display path.

---
 rtl/multiplier_package.sv | 17 +
 rtl/multiplier_shift_add_control.sv | 76 +++++++
 rtl/multiplier_shift_add.sv | 99 +++++++++
 tb/tb_multiplier_shift_add.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_package.sv
// Shared types and helpers for the shift-and-add multiplier.
package multiplier_package;

    // Sequencer states: load in IDLE, then WIDTH ADD/SHIFT pairs, then FIX.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        FIX   = 2'd3
    } state_t;

    // The counter has to hold the value WIDTH itself, so it needs clog2(WIDTH+1) bits.
    function automatic int counter_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multiplier_shift_add_control.sv
// Sequencer for the shift-and-add multiplier: FSM, datapath strobes, busy/done handshake.
module multiplier_shift_add_control
    import multiplier_package::*;
(
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic counter_zero,
    input  logic multiplier_lsb,
    output logic load,
    output logic add,
    output logic count,
    output logic shift,
    output logic fix,
    output logic busy,
    output logic done
);

    state_t state;
    state_t next_state;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: registered state always uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and one-cycle strobes to the datapath.
    always_comb begin
        // NOTE: every output gets a default first so no path can leave a latch behind.
        next_state = state;
        load       = 1'b0;
        add        = 1'b0;
        count      = 1'b0;
        shift      = 1'b0;
        fix        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = ADD;
                end
            end
            ADD: begin
                add        = multiplier_lsb;
                count      = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                shift      = 1'b1;
                next_state = counter_zero ? FIX : ADD;
            end
            FIX: begin
                fix        = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered handshake: busy follows the upcoming state, done pulses as FIX retires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (state == FIX);
        end
    end

endmodule

// File: rtl/multiplier_shift_add.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement, 2*WIDTH-bit product.
module multiplier_shift_add
    import multiplier_package::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              COUNTER_BITS = counter_width(WIDTH);
    localparam logic [COUNTER_BITS-1:0] COUNT_INIT = COUNTER_BITS'(WIDTH);

    logic                    load;
    logic                    add;
    logic                    count;
    logic                    shift;
    logic                    fix;
    logic                    counter_zero;

    logic [WIDTH-1:0]        multiplicand;
    logic [WIDTH-1:0]        multiplier;
    logic [WIDTH-1:0]        accumulator;
    logic                    carry;
    logic                    negate_flag;
    logic [COUNTER_BITS-1:0] counter;

    logic [WIDTH-1:0]        magnitude_a;
    logic [WIDTH-1:0]        magnitude_b;
    logic [WIDTH:0]          sum;
    logic [2*WIDTH-1:0]      raw_product;

    // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude.
    assign magnitude_a  = (signed_mode && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign magnitude_b  = (signed_mode && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    assign sum          = {1'b0, accumulator} + {1'b0, multiplicand};
    assign raw_product  = {accumulator, multiplier};
    assign counter_zero = (counter == '0);

    multiplier_shift_add_control control (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .counter_zero   (counter_zero),
        .multiplier_lsb (multiplier[0]),
        .load           (load),
        .add            (add),
        .count          (count),
        .shift          (shift),
        .fix            (fix),
        .busy           (busy),
        .done           (done)
    );

    // Datapath: operand capture, conditional add, joint right shift, sign fix-up.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: these are plain flops, not a memory, so all of them reset; an abort clears product too.
        if (reset) begin
            multiplicand <= '0;
            multiplier   <= '0;
            accumulator  <= '0;
            carry        <= 1'b0;
            negate_flag  <= 1'b0;
            counter      <= '0;
            product      <= '0;
        end else begin
            if (load) begin
                multiplicand <= magnitude_a;
                multiplier   <= magnitude_b;
                accumulator  <= '0;
                carry        <= 1'b0;
                negate_flag  <= signed_mode & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                counter      <= COUNT_INIT;
            end
            if (add) begin
                {carry, accumulator} <= sum;
            end
            if (count) begin
                counter <= counter - COUNTER_BITS'(1);
            end
            if (shift) begin
                carry       <= 1'b0;
                accumulator <= {carry, accumulator[WIDTH-1:1]};
                multiplier  <= {accumulator[0], multiplier[WIDTH-1:1]};
            end
            if (fix) begin
                product <= negate_flag ? -raw_product : raw_product;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_shift_add.sv
// Self-checking bench: WIDTH=4 and WIDTH=8 instances against a cycle-level reference model.
module tb_multiplier_shift_add;

    logic        clock = 1'b0;
    logic        reset4, reset8;
    logic        start4, start8;
    logic        sm4, sm8;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic        busy4, busy8, done4, done8;
    logic [7:0]  product4;
    logic [15:0] product8;

    int tests = 0;
    int fails = 0;

    // Reference model state, index 0 = WIDTH 4, index 1 = WIDTH 8.
    int          remain [2];
    logic        exp_busy [2];
    logic        exp_done [2];
    logic [63:0] exp_prod [2];
    logic [63:0] pending [2];

    always #5 clock = ~clock;

    multiplier_shift_add #(.WIDTH(4)) dut4 (
        .clock(clock), .reset(reset4), .start(start4), .signed_mode(sm4),
        .operand_a(a4), .operand_b(b4), .busy(busy4), .done(done4), .product(product4)
    );

    multiplier_shift_add #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset8), .start(start8), .signed_mode(sm8),
        .operand_a(a8), .operand_b(b8), .busy(busy8), .done(done8), .product(product8)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Plain integer multiply of the operands as the mode interprets them, truncated to 2*w bits.
    function automatic logic [63:0] ref_product(input int w, input logic sm,
                                                input logic [31:0] a, input logic [31:0] b);
        longint va, vb, p;
        va = longint'(a);
        vb = longint'(b);
        if (sm) begin
            if (a[w-1]) va = va - (longint'(1) << w);
            if (b[w-1]) vb = vb - (longint'(1) << w);
        end
        p = va * vb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // One clock edge of the model: a result appears 2*w+1 edges after an accepted start.
    task automatic step(input int d, input int w, input logic rst, input logic st,
                        input logic sm, input logic [31:0] a, input logic [31:0] b);
        if (rst) begin
            remain[d]   = 0;
            exp_busy[d] = 1'b0;
            exp_done[d] = 1'b0;
            exp_prod[d] = '0;
        end else begin
            exp_done[d] = 1'b0;
            if (remain[d] > 0) begin
                remain[d]--;
                if (remain[d] == 0) begin
                    exp_prod[d] = pending[d];
                    exp_done[d] = 1'b1;
                    exp_busy[d] = 1'b0;
                end
            end else if (st) begin
                pending[d]  = ref_product(w, sm, a, b);
                remain[d]   = 2 * w + 1;
                exp_busy[d] = 1'b1;
            end
        end
    endtask

    // Advance the model on every rising edge; inputs only change 2 time units after it.
    always @(posedge clock) begin
        step(0, 4, reset4, start4, sm4, 32'(a4), 32'(b4));
        step(1, 8, reset8, start8, sm8, 32'(a8), 32'(b8));
    end

    // Compare both instances with the model every cycle; a live reset forces the expectation to 0.
    always @(negedge clock) begin
        check("busy4",    64'(busy4),    reset4 ? 64'd0 : 64'(exp_busy[0]));
        check("done4",    64'(done4),    reset4 ? 64'd0 : 64'(exp_done[0]));
        check("product4", 64'(product4), reset4 ? 64'd0 : exp_prod[0]);
        check("busy8",    64'(busy8),    reset8 ? 64'd0 : 64'(exp_busy[1]));
        check("done8",    64'(done8),    reset8 ? 64'd0 : 64'(exp_done[1]));
        check("product8", 64'(product8), reset8 ? 64'd0 : exp_prod[1]);
    end

    // Count rising edges until done is seen on the following falling edge, bounded.
    task automatic wait_done(input int d, output int cycles);
        bit found = 0;
        cycles = 0;
        while (!found && cycles < 100) begin
            @(posedge clock);
            cycles++;
            @(negedge clock);
            if ((d == 0) ? done4 : done8) found = 1;
        end
        if (!found) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic op4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                       output int cycles, output logic [7:0] prod);
        @(posedge clock); #2;
        start4 = 1'b1; sm4 = sm; a4 = a; b4 = b;
        @(posedge clock); #2;
        start4 = 1'b0;
        wait_done(0, cycles);
        check("busy4_low_in_done_cycle", 64'(busy4), 64'd0);
        prod = product4;
    endtask

    task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                       output int cycles, output logic [15:0] prod);
        @(posedge clock); #2;
        start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
        @(posedge clock); #2;
        start8 = 1'b0;
        wait_done(1, cycles);
        check("busy8_low_in_done_cycle", 64'(busy8), 64'd0);
        prod = product8;
    endtask

    initial begin
        int          cycles;
        logic [7:0]  p4;
        logic [15:0] p8;
        logic        sm;
        logic [3:0]  ra4, rb4;
        logic [7:0]  ra8, rb8;

        for (int d = 0; d < 2; d++) begin
            remain[d] = 0; exp_busy[d] = 0; exp_done[d] = 0; exp_prod[d] = '0; pending[d] = '0;
        end
        reset4 = 1'b1; reset8 = 1'b1;
        start4 = 1'b0; start8 = 1'b0;
        sm4 = 1'b0; sm8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clock);
        #2;
        reset4 = 1'b0; reset8 = 1'b0;
        @(negedge clock);
        check("reset_busy4",    64'(busy4),    64'd0);
        check("reset_done4",    64'(done4),    64'd0);
        check("reset_product4", 64'(product4), 64'd0);
        check("reset_product8", 64'(product8), 64'd0);

        // WIDTH=4 directed cases.
        op4(1'b0, 4'd13, 4'd11, cycles, p4);
        check("u4_13x11", 64'(p4), 64'h8F);
        check("u4_latency", 64'(cycles), 64'd9);
        op4(1'b1, 4'hD, 4'd5, cycles, p4);
        check("s4_m3x5", 64'(p4), 64'hF1);
        op4(1'b1, 4'h8, 4'h8, cycles, p4);
        check("s4_m8xm8", 64'(p4), 64'h40);
        op4(1'b1, 4'h8, 4'd7, cycles, p4);
        check("s4_m8x7", 64'(p4), 64'hC8);

        // WIDTH=8 directed cases.
        op8(1'b0, 8'd255, 8'd255, cycles, p8);
        check("u8_255x255", 64'(p8), 64'hFE01);
        op8(1'b0, 8'd0, 8'd200, cycles, p8);
        check("u8_0x200", 64'(p8), 64'h0000);
        check("u8_zero_latency", 64'(cycles), 64'd17);
        op8(1'b1, 8'hFF, 8'hFF, cycles, p8);
        check("s8_m1xm1", 64'(p8), 64'h0001);

        // Start pulsed at cycle 3 of a running operation must be ignored.
        @(posedge clock); #2;
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'd100; b8 = 8'd3;
        @(posedge clock); #2;
        start8 = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        start8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
        @(posedge clock); #2;
        start8 = 1'b0;
        wait_done(1, cycles);
        check("ignore_start_product", 64'(product8), 64'd300);
        @(posedge clock); #2;
        check("ignore_start_no_second_op", 64'(busy8), 64'd0);

        // Start held through the done cycle: second operation follows directly.
        start8 = 1'b1; a8 = 8'd12; b8 = 8'd10;
        @(posedge clock); #2;
        a8 = 8'd200; b8 = 8'd3;
        wait_done(1, cycles);
        check("b2b_first_product", 64'(product8), 64'd120);
        cycles = 0;
        begin
            bit found = 0;
            while (!found && cycles < 100) begin
                @(posedge clock); #2;
                start8 = 1'b0;
                cycles++;
                @(negedge clock);
                if (done8) found = 1;
            end
            if (!found) check("b2b_timeout", 64'd0, 64'd1);
        end
        check("b2b_done_spacing", 64'(cycles), 64'd18);
        check("b2b_second_product", 64'(product8), 64'd600);

        // Reset mid-operation aborts; a start coincident with reset is dropped.
        @(posedge clock); #2;
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'd13; b4 = 4'd11;
        @(posedge clock); #2;
        start4 = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset4 = 1'b1;
        #1;
        check("abort_busy4",    64'(busy4),    64'd0);
        check("abort_done4",    64'(done4),    64'd0);
        check("abort_product4", 64'(product4), 64'd0);
        @(posedge clock); #2;
        start4 = 1'b1;
        @(posedge clock); #2;
        start4 = 1'b0;
        reset4 = 1'b0;
        @(negedge clock);
        check("reset_start_not_captured", 64'(busy4), 64'd0);
        op4(1'b0, 4'd15, 4'd15, cycles, p4);
        check("u4_15x15_after_abort", 64'(p4), 64'hE1);

        // Randomised operands in both modes; the compare process checks every cycle too.
        for (int i = 0; i < 30; i++) begin
            sm  = 1'($urandom_range(0, 1));
            ra4 = 4'($urandom);
            rb4 = 4'($urandom);
            op4(sm, ra4, rb4, cycles, p4);
            check("rand4_product", 64'(p4), ref_product(4, sm, 32'(ra4), 32'(rb4)));
            check("rand4_latency", 64'(cycles), 64'd9);
        end
        for (int i = 0; i < 30; i++) begin
            sm  = 1'($urandom_range(0, 1));
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            op8(sm, ra8, rb8, cycles, p8);
            check("rand8_product", 64'(p8), ref_product(8, sm, 32'(ra8), 32'(rb8)));
            check("rand8_latency", 64'(cycles), 64'd17);
        end

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
